rv_multicycle_ctrl: RTL

Multi-cycle RISC-V control unit FSM; successor to the single-cycle combinational `control` decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles, sharing one ALU and one memory port.
- Adds memory request/ready handshake, a wait timeout, all six branch types, and sticky illegal/bus-error trap.
- Sits between the instruction register (opcode/funct fields), the ALU zero flag and the datapath muxes/enables.

---
 rtl/rv_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_multicycle_ctrl
// Function : Multi-cycle RISC-V control FSM (fetch/decode/execute/mem/wb)
//            with a memory handshake timeout and a sticky trap.
//            Define RV_CTRL_PERF_CNT_EN to add cycle/instret counters.
// Revision : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_CNT_W    = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef RV_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_SLT  = 4'b1000;
    localparam logic [3:0] c_SLTU = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_LUI, S_TRAP
    } state_t;

    state_t              r_state_q, w_state_d;
    logic [1:0]          r_cause_q, w_cause_d;
    logic [TO_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic                w_to_hit;
    logic                w_unused_f7;

    assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  f_alu = (is_r && alt) ? c_SUB : c_ADD;
            3'b001:  f_alu = 4'b0101;
            3'b010:  f_alu = c_SLT;
            3'b011:  f_alu = c_SLTU;
            3'b100:  f_alu = 4'b0100;
            3'b101:  f_alu = alt ? 4'b0111 : 4'b0110;
            3'b110:  f_alu = 4'b0011;
            default: f_alu = 4'b0010;
        endcase
    endfunction

    // The limit cycle is the one where the counter already equals MEM_TIMEOUT;
    // a mem_ready arriving in that same cycle still completes the access.
    assign w_to_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready &&
                      (r_cnt_q == TO_CNT_W'(MEM_TIMEOUT));

    assign trap       = (r_state_q == S_TRAP);
    assign trap_cause = r_cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_FETCH;
            r_cause_q <= 2'b00;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cause_q <= w_cause_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_state_d != r_state_q)
            w_cnt_d = '0;
        else if (mem_req && !mem_ready)
            w_cnt_d = r_cnt_q + 1'b1;
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_cause_d   = r_cause_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 3'b000;
        alu_control = c_ADD;
        case (r_state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    w_state_d = S_DECODE;
                end else if (w_to_hit) begin
                    w_state_d = S_TRAP;
                    w_cause_d = 2'b10;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (opcode)
                    c_OP_R:                w_state_d = S_EXEC_R;
                    c_OP_I:                w_state_d = S_EXEC_I;
                    c_OP_LOAD, c_OP_STORE: w_state_d = S_MEM_ADR;
                    c_OP_BR:               w_state_d = S_BRANCH;
                    c_OP_JAL:              w_state_d = S_JAL;
                    c_OP_LUI:              w_state_d = S_LUI;
                    default: begin
                        w_state_d = S_TRAP;
                        w_cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = f_alu(funct3, funct7[5], 1'b1);
                w_state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = f_alu(funct3, funct7[5], 1'b0);
                w_state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                w_state_d = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (opcode == c_OP_STORE) ? 3'b001 : 3'b000;
                w_state_d = (opcode == c_OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = (r_state_q == S_MEM_WR);
                adr_src   = 1'b1;
                if (mem_ready) begin
                    w_state_d = (r_state_q == S_MEM_WR) ? S_FETCH : S_MEM_WB;
                end else if (w_to_hit) begin
                    w_state_d = S_TRAP;
                    w_cause_d = 2'b10;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                w_state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                imm_src   = 3'b010;
                w_state_d = S_FETCH;
                // GE/GEU reuse SLT/SLTU: a zero result means the "less" test failed
                case (funct3)
                    3'b000:  begin alu_control = c_SUB;  pc_write = alu_zero;  end
                    3'b001:  begin alu_control = c_SUB;  pc_write = !alu_zero; end
                    3'b100:  begin alu_control = c_SLT;  pc_write = !alu_zero; end
                    3'b101:  begin alu_control = c_SLT;  pc_write = alu_zero;  end
                    3'b110:  begin alu_control = c_SLTU; pc_write = !alu_zero; end
                    3'b111:  begin alu_control = c_SLTU; pc_write = alu_zero;  end
                    default: begin
                        w_state_d = S_TRAP;
                        w_cause_d = 2'b01;
                    end
                endcase
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                w_state_d = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_src   = 3'b011;
                w_state_d = S_ALU_WB;
            end
            S_TRAP:  w_state_d = S_TRAP;
            default: w_state_d = S_FETCH;
        endcase
    end

`ifdef RV_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_q, r_instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_q   <= '0;
            r_instret_q <= '0;
        end else begin
            if (r_state_q != S_TRAP)
                r_cycle_q <= r_cycle_q + 1'b1;
            if ((w_state_d == S_FETCH) && (r_state_q != S_FETCH))
                r_instret_q <= r_instret_q + 1'b1;
        end
    end

    assign cycle_cnt   = r_cycle_q;
    assign instret_cnt = r_instret_q;
`else
    logic [CNT_W-1:0] w_unused_perf;
    assign w_unused_perf = '0;
`endif

endmodule
`default_nettype wire
